uart_buffered_echo: RTL
=======================

Name: uart_buffered_echo

Overview:
- Parametrised UART that joins a receiver, a synchronous RX FIFO and a transmitter.
- Adds configurable data width and parity, frame/parity/overrun error detection, and buffering of received bytes.
- Has two modes. In echo mode, bytes are drained from the FIFO back out on TX automatically. In host mode, a host pops RX bytes and supplies its own TX bytes.
- Sits between the board serial pins and the user logic/LED debug outputs.

Parameters:
- CLKS_PER_BIT, 5208, clock cycles per bit (9600 baud at 50 MHz); must be >= 4.
- DATA_BITS, 8, data bits per frame, legal 5..8.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- FIFO_DEPTH, 16, RX FIFO entries; power of two, >= 2.

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Rx_Serial  in  1  serial input; idle high.
- i_Echo_En  in  1  1 = echo mode, 0 = host mode.
- i_Tx_DV  in  1  host TX request; honoured only when o_Tx_Ready = 1.
- i_Tx_Byte  in  DATA_BITS  host TX data.
- o_Tx_Ready  out  1  TX idle, host mode, and no TX start in the current cycle.
- i_Rd_En  in  1  pop the FIFO head (host mode only).
- o_Rd_Byte  out  DATA_BITS  FIFO head, first-word-fall-through.
- o_Rd_Valid  out  1  FIFO not empty.
- o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- o_Rx_DV  out  1  one-cycle pulse per good received byte.
- o_Tx_Serial  out  1  serial output; idle high.
- o_Tx_Active  out  1  TX frame in progress.
- o_Tx_Done  out  1  one-cycle pulse at the end of the stop bit.
- i_Err_Clr  in  1  clears all sticky error flags.
- o_Frame_Err, o_Parity_Err, o_Overrun  out  1 each  sticky error flags.

Behaviour:
- Clocking and reset: single clock domain (i_Clock). Reset is synchronous and active-high (i_Reset).
- Input sync: i_Rx_Serial passes through a 2-flop synchroniser before the RX FSM.
- Reset values:
  - o_Tx_Serial = 1.
  - o_Tx_Active = o_Tx_Done = o_Rx_DV = 0.
  - FIFO empty: o_Rd_Valid = 0, o_Fifo_Count = 0, o_Rd_Byte = 0.
  - All error flags = 0.
  - Both FSMs in IDLE.
  - o_Tx_Ready = !i_Echo_En.
- Reset mid-frame: reset aborts the frame immediately, with no partial FIFO write and no Tx_Done pulse.
- RX FSM, states IDLE -> START -> DATA -> PARITY -> STOP -> CLEANUP:
  - IDLE -> START on a synchronised low.
  - In START, sample at CLKS_PER_BIT/2. If high, treat as a glitch and return to IDLE. If low, go to DATA.
  - DATA samples DATA_BITS bits LSB first, each CLKS_PER_BIT after the previous sample.
  - PARITY is skipped when PARITY_MODE = 0.
  - STOP samples one bit.
  - CLEANUP lasts 1 cycle, then IDLE.
- Byte disposition at CLEANUP:
  - Stop bit sampled 0: set o_Frame_Err and discard the byte.
  - Parity mismatch: set o_Parity_Err and discard the byte.
  - Both conditions: set both flags.
  - Otherwise: pulse o_Rx_DV and push the byte to the FIFO.
  - If the FIFO is full and no pop happens that cycle: drop the byte, set o_Overrun. o_Rx_DV still pulses.
- FIFO:
  - A push and a pop in the same cycle when full: both succeed; count unchanged.
  - Push and pop in the same cycle when empty: the push succeeds; the pop is ignored.
  - A pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Echo mode (i_Echo_En = 1):
  - When o_Rd_Valid = 1 and TX is IDLE, pop the head and start TX in the same cycle.
  - i_Rd_En, i_Tx_DV are ignored and o_Tx_Ready = 0.
  - Switching modes mid-frame does not abort the frame in progress.
- Host mode: i_Rd_En pops the FIFO. i_Tx_DV with o_Tx_Ready = 1 latches i_Tx_Byte.
- TX FSM, states IDLE -> START -> DATA -> PARITY -> STOP -> DONE:
  - The start bit is driven from the cycle after acceptance.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - Parity is computed per PARITY_MODE.
  - o_Tx_Active is 1 from START through STOP.
  - DONE lasts 1 cycle: o_Tx_Done = 1, o_Tx_Active = 0, line high.
  - Frame length in cycles = CLKS_PER_BIT * (2 + DATA_BITS + (PARITY_MODE != 0)).
- Error flags: once set, they stay set until i_Err_Clr. If i_Err_Clr and a new error occur in the same cycle, the flag ends up set.

Decomposition:
- Shared include file: PARITY_NONE / PARITY_EVEN / PARITY_ODD constants and the RX/TX state encodings.
- One natural sub-module: sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, count, full, empty).
- RX and TX FSMs stay inline in uart_buffered_echo.

Test Plan (CLKS_PER_BIT = 8 in the bench):
1. Echo, 8N1 (DATA_BITS = 8, PARITY_MODE = 0):
   - Send 0xA5 on i_Rx_Serial.
   - Expect one o_Rx_DV pulse.
   - Then 0xA5 framed on o_Tx_Serial: 80-cycle frame, o_Tx_Done pulsed once, FIFO back to 0.
2. Host mode, FIFO_DEPTH = 4:
   - Send 0x11, 0x22, 0x33, 0x44, 0x55.
   - Expect o_Fifo_Count = 4 and o_Overrun = 1.
   - Pops return 0x11..0x44 in order, then o_Rd_Valid = 0.
3. Even parity:
   - Send 0x03 with parity bit 1 (wrong).
   - Expect o_Parity_Err = 1, no o_Rx_DV, count unchanged.
   - Pulse i_Err_Clr: flag clears.
4. Framing:
   - Send 0x5A with stop bit 0 -> o_Frame_Err = 1, byte discarded.
   - 4-cycle start glitch -> no activity, FSM back in IDLE.
5. Host TX, DATA_BITS = 7, odd parity:
   - i_Tx_DV with 0x41 -> serial bits 0, 1000001, parity 1, 1.
   - o_Tx_Ready = 0 during the frame; a second i_Tx_DV during the frame is ignored.
6. Reset mid-frame:
   - Assert i_Reset during a TX data bit and an RX data bit.
   - Next cycle: o_Tx_Serial = 1, o_Tx_Active = 0, count 0, flags 0, no o_Tx_Done pulse.

Source files
------------

// File: rtl/uart_buffered_echo_pkg.sv
// Shared definitions for the buffered UART echo block: parity modes,
// RX/TX state encodings and the parity helper used by both directions.
package uart_buffered_echo_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_PARITY  = 3'd3,
    RX_STOP    = 3'd4,
    RX_CLEANUP = 3'd5
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4,
    TX_DONE   = 3'd5
  } tx_state_e;

  // Parity bit over the low nbits of data; even mode gives the XOR of the
  // bits, odd mode its complement.
  function automatic logic calc_parity(input logic [7:0] data, input int nbits, input int mode);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < nbits) p = p ^ data[i];
    end
    if (mode == PARITY_ODD) p = ~p;
    return p;
  endfunction

endpackage

// File: rtl/uart_buffered_echo_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read port. The head word is
// presented combinationally and reads as zero while the FIFO is empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign count = count_q;
  assign dout  = empty ? '0 : mem[rd_ptr_q];

  // Pop only when data exists; push when space exists or a pop frees a slot
  // in the same cycle. Pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because empty masks the output.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/uart_buffered_echo.sv
// UART receiver + RX FIFO + transmitter. In echo mode received bytes are
// sent straight back out; in host mode the host pops RX data and feeds TX.
module uart_buffered_echo
  import uart_buffered_echo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          i_Rx_Serial,
  input  logic                          i_Echo_En,
  input  logic                          i_Tx_DV,
  input  logic [DATA_BITS-1:0]          i_Tx_Byte,
  output logic                          o_Tx_Ready,
  input  logic                          i_Rd_En,
  output logic [DATA_BITS-1:0]          o_Rd_Byte,
  output logic                          o_Rd_Valid,
  output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
  output logic                          o_Rx_DV,
  output logic                          o_Tx_Serial,
  output logic                          o_Tx_Active,
  output logic                          o_Tx_Done,
  input  logic                          i_Err_Clr,
  output logic                          o_Frame_Err,
  output logic                          o_Parity_Err,
  output logic                          o_Overrun
);

  localparam int         CW         = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0] IDX_LAST   = 3'(DATA_BITS - 1);
  localparam logic       HAS_PARITY = (PARITY_MODE != PARITY_NONE);

  // ---------------- RX side ----------------
  logic                 rx_meta_q, rx_sync_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [2:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_stop_q, rx_stop_d;
  logic                 rx_cleanup, frame_bad, parity_bad, rx_good;

  // ---------------- FIFO ----------------
  logic                 fifo_pop, fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;

  // ---------------- TX side ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 tx_serial_q, tx_serial_d;
  logic                 tx_start;

  // ---------------- Error flags ----------------
  logic frame_err_q, frame_err_d;
  logic parity_err_q, parity_err_d;
  logic overrun_q, overrun_d;
  logic overrun_set;

  // Two-flop synchroniser on the asynchronous serial input (idles high).
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX next-state: half-bit start check, then one sample per bit period.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_data_d  = rx_data_q;
    rx_par_d   = rx_par_q;
    rx_stop_d  = rx_stop_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        rx_idx_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d            = '0;
          rx_data_d[rx_idx_q] = rx_sync_q;
          if (rx_idx_q == IDX_LAST) rx_state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
          else                      rx_idx_d   = rx_idx_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_PARITY: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_par_d   = rx_sync_q;
          rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_stop_d  = rx_sync_q;
          rx_state_d = RX_CLEANUP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_CLEANUP: rx_state_d = RX_IDLE;
      default:    rx_state_d = RX_IDLE;
    endcase
  end

  // RX state registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_data_q  <= '0;
      rx_par_q   <= 1'b0;
      rx_stop_q  <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_data_q  <= rx_data_d;
      rx_par_q   <= rx_par_d;
      rx_stop_q  <= rx_stop_d;
    end
  end

  // Byte disposition during the single CLEANUP cycle.
  assign rx_cleanup  = (rx_state_q == RX_CLEANUP);
  assign frame_bad   = rx_cleanup && !rx_stop_q;
  assign parity_bad  = rx_cleanup && HAS_PARITY &&
                       (rx_par_q != calc_parity(8'(rx_data_q), DATA_BITS, PARITY_MODE));
  assign rx_good     = rx_cleanup && !frame_bad && !parity_bad;
  // A full FIFO can still take the byte if the head leaves this same cycle.
  assign overrun_set = rx_good && fifo_full && !fifo_pop;

  // Echo mode pops exactly when TX launches; host mode pops on request.
  assign fifo_pop = i_Echo_En ? tx_start : i_Rd_En;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (i_Clock),
    .srst  (i_Reset),
    .push  (rx_good),
    .pop   (fifo_pop),
    .din   (rx_data_q),
    .dout  (fifo_dout),
    .count (o_Fifo_Count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // TX next-state; the serial line is derived from the next state so it is
  // registered and changes exactly on bit boundaries.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_idx_d    = tx_idx_q;
    tx_data_d   = tx_data_q;
    tx_start    = 1'b0;
    tx_serial_d = 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        tx_idx_d = '0;
        if (i_Echo_En ? !fifo_empty : i_Tx_DV) begin
          tx_start   = 1'b1;
          tx_data_d  = i_Echo_En ? fifo_dout : i_Tx_Byte;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == IDX_LAST) tx_state_d = HAS_PARITY ? TX_PARITY : TX_STOP;
          else                      tx_idx_d   = tx_idx_q + 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_PARITY: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_DONE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DONE: tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
    case (tx_state_d)
      TX_START:  tx_serial_d = 1'b0;
      TX_DATA:   tx_serial_d = tx_data_d[tx_idx_d];
      TX_PARITY: tx_serial_d = calc_parity(8'(tx_data_d), DATA_BITS, PARITY_MODE);
      default:   tx_serial_d = 1'b1;
    endcase
  end

  // TX state registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= '0;
      tx_data_q   <= '0;
      tx_serial_q <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_data_q   <= tx_data_d;
      tx_serial_q <= tx_serial_d;
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_comb begin
    frame_err_d  = (frame_err_q  && !i_Err_Clr) || frame_bad;
    parity_err_d = (parity_err_q && !i_Err_Clr) || parity_bad;
    overrun_d    = (overrun_q    && !i_Err_Clr) || overrun_set;
  end

  // Error flag registers.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_Tx_Serial  = tx_serial_q;
  assign o_Tx_Active  = (tx_state_q == TX_START) || (tx_state_q == TX_DATA) ||
                        (tx_state_q == TX_PARITY) || (tx_state_q == TX_STOP);
  assign o_Tx_Done    = (tx_state_q == TX_DONE);
  assign o_Tx_Ready   = !i_Echo_En && (tx_state_q == TX_IDLE);
  assign o_Rx_DV      = rx_good;
  assign o_Rd_Byte    = fifo_dout;
  assign o_Rd_Valid   = !fifo_empty;
  assign o_Frame_Err  = frame_err_q;
  assign o_Parity_Err = parity_err_q;
  assign o_Overrun    = overrun_q;

endmodule
